// File: rtl/ghash_ctrl.sv
// GHASH sequencer: feeds one shared bit-serial GF(2^128) multiplier block by block, then length block.
// Optional AAD/CT order checking is compiled in when GHASH_ORDER_CHK_EN is defined.
module ghash_ctrl #(
    parameter int unsigned LEN_W = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         init,
    input  logic [127:0] H_in,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [127:0] blk_data,
    input  logic         blk_type,
    input  logic [4:0]   blk_nbytes,
    input  logic         fin_req,
    output logic [127:0] tag_o,
    output logic         tag_valid,
    output logic         busy,
    output logic         err,
    output logic         mul_start,
    output logic [127:0] mul_H,
    output logic [127:0] mul_block,
    input  logic [127:0] mul_result,
    input  logic         mul_ready
);

    typedef enum logic [2:0] {StReady, StMulStart, StMulWait, StDone, StDrain} state_e;

    state_e           state_q;
    logic [127:0]     y_q, h_q, tag_q, mul_block_q;
    logic [LEN_W-1:0] len_aad_q, len_ct_q;
    logic             tag_valid_q, blk_ready_q, busy_q, mul_start_q, final_q, drain_wait_q;
    logic [7:0]       blk_bits;
    logic [127:0]     len_blk;
    logic             blk_accept, do_clear;

    assign blk_bits   = (blk_nbytes == 5'd0) ? 8'd128 : {blk_nbytes, 3'b000};
    assign len_blk    = {64'(len_aad_q), 64'(len_ct_q)};
    assign blk_accept = (state_q == StReady) && blk_ready_q && blk_valid && !init;
    // DRAIN clears once the in-flight product (if any) has been returned and dropped.
    assign do_clear   = (init && (state_q == StReady || state_q == StDone)) ||
                        (state_q == StDrain && (!drain_wait_q || mul_ready));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StReady;
            y_q          <= '0;
            h_q          <= '0;
            tag_q        <= '0;
            mul_block_q  <= '0;
            len_aad_q    <= '0;
            len_ct_q     <= '0;
            tag_valid_q  <= 1'b0;
            blk_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            mul_start_q  <= 1'b0;
            final_q      <= 1'b0;
            drain_wait_q <= 1'b0;
        end else begin
            mul_start_q <= 1'b0;
            if (init) h_q <= H_in;
            case (state_q)
                StReady: begin
                    if (blk_accept) begin
                        mul_block_q <= y_q ^ blk_data;
                        if (blk_type) len_ct_q <= len_ct_q + LEN_W'(blk_bits);
                        else          len_aad_q <= len_aad_q + LEN_W'(blk_bits);
                        blk_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= StMulStart;
                    end else if (!init && blk_ready_q && fin_req) begin
                        mul_block_q <= y_q ^ len_blk;
                        final_q     <= 1'b1;
                        blk_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= StMulStart;
                    end else begin
                        blk_ready_q <= 1'b1;
                    end
                end
                StMulStart: begin
                    if (init) begin
                        drain_wait_q <= 1'b0;
                        state_q      <= StDrain;
                    end else begin
                        mul_start_q <= 1'b1;
                        state_q     <= StMulWait;
                    end
                end
                StMulWait: begin
                    if (init) begin
                        drain_wait_q <= !mul_ready;
                        state_q      <= StDrain;
                    end else if (mul_ready) begin
                        y_q    <= mul_result;
                        busy_q <= 1'b0;
                        if (final_q) begin
                            tag_q       <= mul_result;
                            tag_valid_q <= 1'b1;
                            state_q     <= StDone;
                        end else begin
                            blk_ready_q <= 1'b1;
                            state_q     <= StReady;
                        end
                    end
                end
                StDone, StDrain: begin
                end
                default: state_q <= StReady;
            endcase
            if (do_clear) begin
                y_q          <= '0;
                len_aad_q    <= '0;
                len_ct_q     <= '0;
                tag_valid_q  <= 1'b0;
                final_q      <= 1'b0;
                drain_wait_q <= 1'b0;
                blk_ready_q  <= 1'b1;
                busy_q       <= 1'b0;
                state_q      <= StReady;
            end
        end
    end

`ifdef GHASH_ORDER_CHK_EN
    logic err_q, ct_seen_q, aad_part_q;

    always_ff @(posedge clk) begin
        if (!reset_n || do_clear) begin
            err_q      <= 1'b0;
            ct_seen_q  <= 1'b0;
            aad_part_q <= 1'b0;
        end else if (blk_accept) begin
            if (!blk_type && (ct_seen_q || aad_part_q)) err_q <= 1'b1;
            if (blk_type) ct_seen_q <= 1'b1;
            else          aad_part_q <= (blk_nbytes != 5'd0) && (blk_nbytes != 5'd16);
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign blk_ready = blk_ready_q;
    assign tag_o     = tag_q;
    assign tag_valid = tag_valid_q;
    assign busy      = busy_q;
    assign mul_start = mul_start_q;
    assign mul_H     = h_q;
    assign mul_block = mul_block_q;

endmodule

// File: tb/tb_ghash_ctrl.sv
// Bench for ghash_ctrl: behavioural GHASH model, emulated mulH, operand and tag scoreboards.
module tb_ghash_ctrl;

    logic         clk = 1'b0, reset_n = 1'b0, init = 1'b0;
    logic         blk_valid = 1'b0, blk_type = 1'b0, fin_req = 1'b0, mul_ready = 1'b0;
    logic [127:0] H_in = '0, blk_data = '0, mul_result = '0;
    logic [4:0]   blk_nbytes = '0;
    logic         blk_ready, tag_valid, busy, err, mul_start;
    logic [127:0] tag_o, mul_H, mul_block;

    ghash_ctrl #(.LEN_W(64)) dut (
        .clk(clk), .reset_n(reset_n), .init(init), .H_in(H_in),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
        .blk_type(blk_type), .blk_nbytes(blk_nbytes), .fin_req(fin_req),
        .tag_o(tag_o), .tag_valid(tag_valid), .busy(busy), .err(err),
        .mul_start(mul_start), .mul_H(mul_H), .mul_block(mul_block),
        .mul_result(mul_result), .mul_ready(mul_ready)
    );

    always #5 clk = ~clk;

    int checks = 0, passes = 0;
    int start_cnt = 0, ready_cnt = 0, fixed_lat = 0;
    logic [127:0] last_op = '0;
    logic [127:0] q_op[$], q_h[$], q_tag[$];

    // Reference model state
    logic [127:0] m_y = '0, m_h = '0;
    logic [63:0]  m_len_aad = '0, m_len_ct = '0;
    bit           m_err = 0, m_ct_seen = 0, m_aad_part = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        checks++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    function automatic logic [127:0] gfmul(input logic [127:0] a, input logic [127:0] b);
        logic [127:0] r, s;
        r = '0;
        s = a;
        for (int i = 0; i < 128; i++) begin
            if (b[i]) r ^= s;
            s = s[127] ? ((s << 1) ^ 128'h87) : (s << 1);
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_init(input logic [127:0] h);
        m_y = '0; m_h = h; m_len_aad = '0; m_len_ct = '0;
        m_err = 0; m_ct_seen = 0; m_aad_part = 0;
    endtask

    task automatic model_blk(input logic [127:0] d, input bit t, input logic [4:0] nb);
        logic [127:0] op;
        logic [63:0]  bits;
        op = m_y ^ d;
        q_op.push_back(op);
        q_h.push_back(m_h);
        m_y = gfmul(op, m_h);
        bits = (nb == 0) ? 64'd128 : 64'(nb) * 64'd8;
        if (t) m_len_ct += bits;
        else   m_len_aad += bits;
`ifdef GHASH_ORDER_CHK_EN
        if (!t && (m_ct_seen || m_aad_part)) m_err = 1;
        if (t) m_ct_seen = 1;
        else   m_aad_part = (nb != 0 && nb != 16);
`endif
    endtask

    task automatic model_fin();
        logic [127:0] op;
        op = m_y ^ {m_len_aad, m_len_ct};
        q_op.push_back(op);
        q_h.push_back(m_h);
        m_y = gfmul(op, m_h);
        q_tag.push_back(m_y);
    endtask

    // Emulated mulH: checks operands against the scoreboard and returns the product later.
    initial begin
        logic [127:0] op, hh;
        int lat;
        bit stable;
        forever begin
            @(negedge clk);
            if (mul_start === 1'b1) begin
                op = mul_block; hh = mul_H; last_op = op; start_cnt++;
                if (q_op.size() == 0) fail_now("mul_start_unexpected");
                else begin
                    check("mul_block", op, q_op.pop_front());
                    check("mul_H", hh, q_h.pop_front());
                end
                lat = (fixed_lat != 0) ? fixed_lat : $urandom_range(2, 40);
                stable = 1;
                @(negedge clk);
                check("mul_start_width", 128'(mul_start), 128'd0);
                repeat (lat - 2) begin
                    if (mul_block !== op) stable = 0;
                    @(negedge clk);
                end
                check("mul_block_stable", 128'(stable), 128'd1);
                mul_result = gfmul(op, hh);
                mul_ready = 1'b1;
                ready_cnt++;
                @(negedge clk);
                mul_ready = 1'b0;
                mul_result = rand128();
            end
        end
    end

    // Tag monitor
    initial begin
        bit prev;
        prev = 0;
        forever begin
            @(negedge clk);
            if (tag_valid === 1'b1 && !prev) begin
                if (q_tag.size() == 0) fail_now("tag_unexpected");
                else check("tag", tag_o, q_tag.pop_front());
            end
            prev = (tag_valid === 1'b1);
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (blk_ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) fail_now("blk_ready_timeout");
    endtask

    task automatic wait_tag();
        int n = 0;
        while (tag_valid !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) fail_now("tag_valid_timeout");
    endtask

    task automatic do_init(input logic [127:0] h);
        init = 1'b1; H_in = h;
        model_init(h);
        @(negedge clk);
        init = 1'b0;
    endtask

    task automatic send_blk(input logic [127:0] d, input bit t, input logic [4:0] nb);
        wait_ready();
        blk_valid = 1'b1; blk_data = d; blk_type = t; blk_nbytes = nb;
        model_blk(d, t, nb);
        @(negedge clk);
        blk_valid = 1'b0;
    endtask

    task automatic finalize();
        wait_ready();
        fin_req = 1'b1;
        model_fin();
        @(negedge clk);
        fin_req = 1'b0;
        wait_tag();
    endtask

    initial begin
        int s0, rc0, n;
        logic [127:0] h2;
        // Reset with blk_valid asserted
        blk_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_blk_ready_in_reset", 128'(blk_ready), 128'd0);
        reset_n = 1'b1; blk_valid = 1'b0;
        @(negedge clk);
        check("rst_blk_ready", 128'(blk_ready), 128'd1);
        check("rst_tag_valid", 128'(tag_valid), 128'd0);
        check("rst_err", 128'(err), 128'd0);
        check("rst_mul_start", 128'(mul_start), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_tag_o", tag_o, 128'd0);

        // Identity key
        do_init(128'h1);
        s0 = start_cnt;
        send_blk(128'h1, 1'b0, 5'd16);
        send_blk(128'hF0, 1'b1, 5'd0);
        finalize();
        check("id_tag", tag_o, {64'h80, 64'h71});
        check("id_tag_valid", 128'(tag_valid), 128'd1);
        check("id_starts", 128'(start_cnt - s0), 128'd3);
        check("done_blk_ready", 128'(blk_ready), 128'd0);
        check("done_busy", 128'(busy), 128'd0);
        blk_valid = 1'b1; fin_req = 1'b1;
        repeat (6) @(negedge clk);
        blk_valid = 1'b0; fin_req = 1'b0;
        check("done_ignores_input", 128'(start_cnt - s0), 128'd3);
        check("done_tag_held", 128'(tag_valid), 128'd1);

        // Zero key
        do_init(128'h0);
        check("init_clears_tag_valid", 128'(tag_valid), 128'd0);
        for (int i = 0; i < 3; i++) send_blk({128{1'b1}}, 1'b1, 5'd0);
        finalize();
        check("zero_tag", tag_o, 128'd0);
        check("zero_len_block", last_op, {64'h0, 64'd384});

        // Partial block with fin_req in the same cycle
        do_init(128'h1);
        wait_ready();
        blk_valid = 1'b1; blk_data = 128'h0; blk_type = 1'b1; blk_nbytes = 5'd5; fin_req = 1'b1;
        model_blk(128'h0, 1'b1, 5'd5);
        model_fin();
        @(negedge clk);
        blk_valid = 1'b0;
        wait_tag();
        fin_req = 1'b0;
        check("prio_tag", tag_o, {64'h0, 64'd40});

        // Init while a multiply is in flight
        do_init(rand128());
        fixed_lat = 130;
        s0 = start_cnt;
        send_blk(rand128(), 1'b1, 5'd0);
        n = 0;
        while (start_cnt == s0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) fail_now("drain_start_timeout");
        repeat (9) @(negedge clk);
        rc0 = ready_cnt;
        h2 = rand128();
        do_init(h2);
        check("drain_blk_ready", 128'(blk_ready), 128'd0);
        check("drain_busy", 128'(busy), 128'd1);
        wait_ready();
        check("drain_waits_mul_ready", 128'(ready_cnt > rc0), 128'd1);
        check("drain_no_tag", 128'(tag_valid), 128'd0);
        fixed_lat = 0;
        send_blk(rand128(), 1'b0, 5'd0);
        send_blk(rand128(), 1'b1, 5'd9);
        finalize();

        // Order check: CT then AAD
        do_init(rand128());
        send_blk(rand128(), 1'b1, 5'd0);
        send_blk(rand128(), 1'b0, 5'd0);
        wait_ready();
`ifdef GHASH_ORDER_CHK_EN
        check("order_err_set", 128'(err), 128'd1);
`else
        check("order_err_tied", 128'(err), 128'd0);
`endif
        finalize();
        check("order_err_after_fin", 128'(err), 128'(m_err));
        do_init(rand128());
        check("order_err_cleared", 128'(err), 128'd0);

        // Randomized rounds
        for (int r = 0; r < 8; r++) begin
            do_init(rand128());
            n = $urandom_range(1, 4);
            for (int b = 0; b < n; b++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                send_blk(rand128(), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 16)));
            end
            finalize();
            check("rand_err", 128'(err), 128'(m_err));
        end

        repeat (5) @(negedge clk);
        check("op_queue_empty", 128'(q_op.size()), 128'd0);
        check("tag_queue_empty", 128'(q_tag.size()), 128'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ghash_ctrl.md
Name: ghash_ctrl

Overview:
- Sequences the bit-serial GF(2^128) multiplier (mulH) to compute GHASH over a stream of AAD and ciphertext blocks for the SNOW-V AEAD path.
- Per block: XOR the block into accumulator Y, launch one multiply by H, wait for the multiplier's ready pulse, store the product in Y.
- On finalize, hashes the length block and presents the result as the tag.
- Sits between the keystream/ciphertext path (upstream) and the single mulH instance (downstream).

Parameters:
- LEN_W, 64, width of each bit-length counter; zero-extended into its 64-bit half of the length block (LEN_W <= 64).

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- init  in  1  pulse: clear Y and lengths, latch H_in
- H_in  in  128  hash key, sampled on init
- blk_valid  in  1  input block valid
- blk_ready  out  1  controller accepts block this cycle
- blk_data  in  128  block, already zero-padded
- blk_type  in  1  0 = AAD, 1 = ciphertext
- blk_nbytes  in  5  valid bytes, 1..16; 0 encodes 16
- fin_req  in  1  level request to finalize
- tag_o  out  128  GHASH result
- tag_valid  out  1  tag_o valid; held until next init
- busy  out  1  high in every state except READY and DONE
- err  out  1  order error, sticky until init
- mul_start  out  1  one-cycle start pulse to mulH
- mul_H  out  128  latched H
- mul_block  out  128  Y ^ block (or Y ^ length block)
- mul_result  in  128  mulH product
- mul_ready  in  1  mulH one-cycle done pulse

Behaviour:
- Reset (reset_n = 0 at a clk edge) clears all outputs and registers (Y, H, both length counters, tag_o, tag_valid, err, mul_start, blk_ready) and sets state = READY.
- States: READY, MUL_START, MUL_WAIT, DONE, DRAIN.
- READY: blk_ready = 1.
  - blk_valid = 1: register mul_block = Y ^ blk_data; add nbytes*8 to len_aad (type 0) or len_ct (type 1); go to MUL_START.
  - blk_valid = 0 and fin_req = 1: register mul_block = Y ^ {len_aad, len_ct}, AAD length in bits [127:64]; set the final flag; go to MUL_START.
  - Block has priority over fin_req in the same cycle.
- MUL_START: mul_start = 1 for exactly one cycle; go to MUL_WAIT.
- MUL_WAIT: hold mul_block stable until mul_ready.
  - On mul_ready: Y <= mul_result.
  - If final flag set: tag_o <= mul_result, tag_valid = 1, go to DONE.
  - Otherwise go to READY.
- The controller never counts multiplier cycles; it relies only on the mul_ready pulse (nominally 130 cycles after mul_start).
- Per-block latency from acceptance to blk_ready high again: 2 + multiplier latency (132 cycles nominal).
- DONE: tag_valid = 1, blk_ready = 0; blk_valid and fin_req are ignored until init.
- init in READY or DONE: Y = 0, lengths = 0, H <= H_in, tag_valid = 0, err = 0, final flag = 0; next state READY. No multiply is issued.
- init in MUL_START or MUL_WAIT: the multiplier cannot be aborted.
  - Latch H_in; go to DRAIN (mul_start is not asserted if init arrives in MUL_START).
  - DRAIN waits for mul_ready if a multiply was started, discards mul_result, then performs the clear and returns to READY.
  - blk_ready = 0 and busy = 1 throughout DRAIN.
- mul_ready outside MUL_WAIT and DRAIN is ignored.
- Length counters wrap modulo 2^LEN_W silently.
- blk_nbytes only affects length accounting; blk_data is not masked.
- H is not modified except by init.

Optional Feature:
- Macro GHASH_ORDER_CHK_EN.
- Defined: accepting an AAD block (blk_type = 0) after any ciphertext block since the last init sets err = 1 (sticky). The block is still processed normally. A partial AAD block (nbytes != 16) followed by another AAD block also sets err.
- Undefined: no order tracking logic; err is tied to 0.

Test Plan:
- Reset: hold reset_n = 0 for 2 clocks with blk_valid = 1 → blk_ready = 1, tag_valid = 0, err = 0, mul_start = 0, tag_o = 0 after release.
- Identity key: init with H_in = 128'h1; AAD 128'h1 (16 B); CT 128'hF0 (16 B); fin_req → mul_start pulses three times; tag_o = {64'h80, 64'h71}, tag_valid = 1.
- Zero key: init with H_in = 0; three CT blocks of all-ones; fin_req → tag_o = 0; length block issued as {64'h0, 64'd384}.
- Partial and priority: H_in = 1; assert blk_valid (CT 128'h0, nbytes = 5) and fin_req together → block accepted first, then finalize; tag_o = {64'h0, 64'd40}.
- Init mid-multiply: assert init 10 cycles after mul_start → no tag; blk_ready stays 0 until the mul_ready pulse, then returns to READY with Y = 0. A new H_in is used for the next block (checked against the reference model).
- GHASH_ORDER_CHK_EN: CT block then AAD block → err = 1 after the second accept; err stays 1 after finalize and clears on init. With the macro undefined, err stays 0.
